// File: rtl/shift_reg_universal.sv
// Universal shift register: bidirectional serial shift, parallel load and hold,
// with a saturating same-direction shift counter and a FULL word flag.
module shift_reg_universal #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             Din,
    input  logic             DinD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SoutU,
    output logic             SoutD,
    output logic [CW-1:0]    CNT,
    output logic             FULL
);

    localparam logic [1:0]    MODE_HOLD = 2'b00;
    localparam logic [1:0]    MODE_UP   = 2'b01;
    localparam logic [1:0]    MODE_DOWN = 2'b10;
    localparam logic [1:0]    MODE_LOAD = 2'b11;
    localparam logic          DIR_UP    = 1'b0;
    localparam logic          DIR_DOWN  = 1'b1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;
    logic             r_full;

    logic [WIDTH-1:0] w_q_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_dir_nxt;

    // Counter stops at WIDTH so FULL stays asserted during a long same-direction run.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    // Next-state decode for data, shift counter and last-direction bit.
    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (EN) begin
            case (MODE)
                MODE_HOLD: begin
                    w_q_nxt = r_q;
                end
                MODE_UP: begin
                    w_q_nxt = {r_q[WIDTH-2:0], Din};
                    if (r_dir == DIR_UP) begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end else begin
                        w_cnt_nxt = CNT_ONE;
                        w_dir_nxt = DIR_UP;
                    end
                end
                MODE_DOWN: begin
                    w_q_nxt = {DinD, r_q[WIDTH-1:1]};
                    if (r_dir == DIR_DOWN) begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end else begin
                        w_cnt_nxt = CNT_ONE;
                        w_dir_nxt = DIR_DOWN;
                    end
                end
                MODE_LOAD: begin
                    w_q_nxt   = D;
                    w_cnt_nxt = {CW{1'b0}};
                end
                default: begin
                    w_q_nxt = r_q;
                end
            endcase
        end else begin
            w_q_nxt = r_q;
        end
    end

    // State registers; FULL is registered from the same next-count value CNT takes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_q    <= {WIDTH{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_dir  <= DIR_UP;
            r_full <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_cnt  <= w_cnt_nxt;
            r_dir  <= w_dir_nxt;
            r_full <= (w_cnt_nxt == CNT_MAX);
        end
    end

    assign Q     = r_q;
    assign CNT   = r_cnt;
    assign FULL  = r_full;
    assign SoutU = r_q[WIDTH-1];
    assign SoutD = r_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=4): directed scenarios plus
// randomized traffic, compared against an arithmetic reference model.
module tb_shift_reg_universal;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          EN = 1'b0;
    logic [1:0]    MODE = 2'b00;
    logic          Din = 1'b0;
    logic          DinD = 1'b0;
    logic [W-1:0]  D = '0;
    logic [W-1:0]  Q;
    logic          SoutU;
    logic          SoutD;
    logic [CW-1:0] CNT;
    logic          FULL;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    // Reference state: value as an integer, run length, last direction (0 = up).
    int m_q   = 0;
    int m_cnt = 0;
    int m_dir = 0;

    shift_reg_universal #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .Din(Din), .DinD(DinD),
        .D(D), .Q(Q), .SoutU(SoutU), .SoutD(SoutD), .CNT(CNT), .FULL(FULL)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            failures_cnt++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int rst, input int en, input int mode,
                                input int din, input int dind, input int d);
        if (rst == 0) begin
            m_q = 0; m_cnt = 0; m_dir = 0;
        end else if (en != 0) begin
            if (mode == 1) begin
                m_q = (m_q * 2 + din) % (1 << W);
                if (m_dir == 0) m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
                else begin m_cnt = 1; m_dir = 0; end
            end else if (mode == 2) begin
                m_q = m_q / 2 + dind * (1 << (W - 1));
                if (m_dir == 1) m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
                else begin m_cnt = 1; m_dir = 1; end
            end else if (mode == 3) begin
                m_q = d; m_cnt = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check_val({tag, "_q"},     int'(Q),     m_q);
        check_val({tag, "_cnt"},   int'(CNT),   m_cnt);
        check_val({tag, "_full"},  int'(FULL),  (m_cnt == W) ? 1 : 0);
        check_val({tag, "_soutu"}, int'(SoutU), (m_q >> (W - 1)) % 2);
        check_val({tag, "_soutd"}, int'(SoutD), m_q % 2);
    endtask

    // Apply one edge with the given inputs, advance the model, compare #1 after the edge.
    task automatic step(input string tag, input logic rst, input logic en, input logic [1:0] mode,
                        input logic din, input logic dind, input logic [W-1:0] d);
        RST = rst; EN = en; MODE = mode; Din = din; DinD = dind; D = d;
        @(posedge CLK);
        model_update(int'(rst), int'(en), int'(mode), int'(din), int'(dind), int'(d));
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        step("rst", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
    endtask

    initial begin
        logic [3:0] bits_up;
        logic [3:0] exp_q_tbl [4];
        bits_up = 4'b1101;
        exp_q_tbl[0] = 4'b0001; exp_q_tbl[1] = 4'b0010;
        exp_q_tbl[2] = 4'b0101; exp_q_tbl[3] = 4'b1011;
        #2;

        // 1: reset held two edges while load of all-ones is requested
        step("s1a", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
        step("s1b", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'hF);
        check_val("s1_q_const", int'(Q), 0);

        // 2: deserialise 1,0,1,1 then saturate
        for (int i = 0; i < 4; i++) begin
            step("s2", 1'b1, 1'b1, 2'b01, bits_up[i], 1'b0, 4'h0);
            check_val("s2_q_const", int'(Q), int'(exp_q_tbl[i]));
            check_val("s2_cnt_const", int'(CNT), i + 1);
        end
        check_val("s2_full_const", int'(FULL), 1);
        step("s2sat", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
        check_val("s2sat_q_const", int'(Q), 6);
        check_val("s2sat_cnt_const", int'(CNT), 4);

        // 3: load then shift down
        step("s3ld", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 4'hA);
        check_val("s3ld_q_const", int'(Q), 10);
        step("s3dn", 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'h0);
        check_val("s3dn_q_const", int'(Q), 13);
        check_val("s3dn_cnt_const", int'(CNT), 1);

        // 4: direction change restarts the run at 1
        do_reset();
        for (int i = 0; i < 3; i++) step("s4up", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        step("s4dn1", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
        check_val("s4_cnt_restart", int'(CNT), 1);
        for (int i = 0; i < 3; i++) step("s4dn", 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'h0);
        check_val("s4_full_const", int'(FULL), 1);

        // 5: EN=0 and MODE=hold do not break the run
        do_reset();
        for (int i = 0; i < 2; i++) step("s5up", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step("s5en0", 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 4'h5);
        check_val("s5_en0_cnt", int'(CNT), 2);
        for (int i = 0; i < 2; i++) step("s5hold", 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 2; i++) step("s5up2", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
        check_val("s5_full_const", int'(FULL), 1);

        // 6: reset mid-shift discards the partial word
        do_reset();
        for (int i = 0; i < 2; i++) step("s6up", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        check_val("s6_q_pre", int'(Q), 3);
        step("s6rst", 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        check_val("s6_q_rst", int'(Q), 0);
        step("s6post", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
        check_val("s6_cnt_post", int'(CNT), 1);

        // Randomized traffic biased toward long shift runs
        for (int i = 0; i < 400; i++) begin
            logic       r_rst;
            logic       r_en;
            logic [1:0] r_mode;
            r_rst  = ($urandom_range(0, 39) != 0);
            r_en   = ($urandom_range(0, 4) != 0);
            r_mode = ($urandom_range(0, 9) < 4) ? 2'b01 :
                     ($urandom_range(0, 5) < 3) ? 2'b10 : 2'($urandom_range(0, 3));
            step("rand", r_rst, r_en, r_mode, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal shift register. It supports bidirectional serial shift, parallel load and hold, and keeps a saturating shift counter with a FULL flag that marks a complete WIDTH-bit serial word. This is the next generation of the team's fixed 4-stage serial-in/parallel-out register. It sits between serial links and parallel datapaths, used as a deserializer (shift, wait FULL, read Q) or a serializer (load, shift, take Sout).

## Interface
Parameters:
- WIDTH, 4, register width in bits; legal range WIDTH >= 2.
- CW, $clog2(WIDTH+1), counter width (derived; do not override).

Ports:
- CLK, input, 1, single clock; all state updates on the rising edge.
- RST, input, 1, reset; synchronous, active-low; sampled on the CLK rising edge.
- EN, input, 1, clock enable; 0 = hold all state.
- MODE, input, 2, operation select: 00 hold, 01 shift up, 10 shift down, 11 parallel load.
- Din, input, 1, serial input for shift up; enters Q[0].
- DinD, input, 1, serial input for shift down; enters Q[WIDTH-1].
- D, input, WIDTH, parallel load data.
- Q, output, WIDTH, register contents (registered); Q[0] is the first stage.
- SoutU, output, 1, shift-up serial out = Q[WIDTH-1] (combinational from Q).
- SoutD, output, 1, shift-down serial out = Q[0] (combinational from Q).
- CNT, output, CW, shifts in the current direction since last load/reset (registered).
- FULL, output, 1, CNT == WIDTH (registered, decoded from CNT register).

## Operation
- Priority at each rising edge: RST==0 > EN==0 > MODE.
- RST==0: Q=0, CNT=0, DIR=0 (internal last-direction bit, 0=up), FULL=0. Takes effect at the same edge regardless of EN and MODE.
- EN==0: Q, CNT and DIR hold; MODE, Din, DinD and D are ignored.
- MODE 00 (hold): Q, CNT and DIR unchanged.
- MODE 01 (shift up): Q <= {Q[WIDTH-2:0], Din}.
  - If DIR==up: CNT <= min(CNT+1, WIDTH).
  - Else: CNT <= 1 and DIR <= up.
- MODE 10 (shift down): Q <= {DinD, Q[WIDTH-1:1]}.
  - If DIR==down: CNT <= min(CNT+1, WIDTH).
  - Else: CNT <= 1 and DIR <= down.
- MODE 11 (load): Q <= D, CNT <= 0. DIR is unchanged.
- Counter saturation:
  - CNT saturates at WIDTH; it never wraps.
  - Further same-direction shifts keep CNT=WIDTH and FULL=1 while Q continues shifting.
- FULL is 1 exactly when the last WIDTH shift operations were all in the same direction, with no intervening load or reset. Hold and EN=0 cycles do not break the run.
- After reset, DIR=up. The first shift up therefore gives CNT=1, and the first shift down also gives CNT=1 (direction change from the reset value).

## Timing
- All outputs are registered except SoutU and SoutD, which are direct wires from Q.
- Latency: one edge. An operation sampled at edge k is visible on Q, CNT and FULL after edge k.
- A deserialised word is valid on Q in the same cycle FULL first rises.
- Serializer: after a load at edge k, SoutU presents D[WIDTH-1] in cycle k+1. Each subsequent shift-up edge presents the next lower bit.
- Reset mid-operation: a single low-sampled edge clears everything; the partial word is discarded.
- There are no multi-cycle paths and no handshake; the consumer samples Q when FULL==1.
- Inputs must meet setup and hold relative to the CLK rising edge. There is no internal synchronisation.

## Test plan
All scenarios use WIDTH=4.
1. Reset: RST=0 for 2 edges with EN=1, MODE=11, D=4'hF -> Q=4'h0, CNT=0, FULL=0. SoutU=0, SoutD=0.
2. Deserialise: shift up with Din = 1,0,1,1 -> Q goes 0001, 0010, 0101, 1011. CNT goes 1,2,3,4. FULL=1 after the 4th edge. A 5th shift with Din=0 -> Q=0110, CNT=4, FULL=1.
3. Load then shift down: load D=4'hA -> Q=1010, CNT=0, FULL=0. Then shift down with DinD=1 -> Q=1101, CNT=1, SoutD=1.
4. Direction change: from reset, 3 shifts up (CNT=3), then 1 shift down -> CNT=1, FULL=0. Then 3 more shifts down -> CNT=4, FULL=1.
5. Enable/hold: after 2 shifts up (CNT=2), hold with EN=0 and MODE=01 for 3 edges -> Q and CNT unchanged. Then MODE=00 with EN=1 for 2 edges -> unchanged. Then 2 more shifts up -> CNT=4, FULL=1 (hold does not break the run).
6. Reset mid-shift: after 2 shifts up with Din=1 (Q=0011), apply RST=0 for 1 edge with MODE=01 -> Q=0, CNT=0, FULL=0. With RST=1, the next shift up with Din=1 gives Q=0001, CNT=1.
